// File: rtl/scroll_bus_if.sv
// scroll_bus_if: time-multiplexed CPU master bus, control/address half.
// Signals: CLK_2H slot phase, CLK_1H address-valid (low = valid),
// A[2:0] address, nWE write strobe, nLATCH0/nLATCH1 plane selects.
// The data bus D is a plain inout on the responder.
interface scroll_bus_if;
    logic       CLK_2H;
    logic       CLK_1H;
    logic [2:0] A;
    logic       nWE;
    logic       nLATCH0;
    logic       nLATCH1;

    modport master (
        output CLK_2H, CLK_1H, A, nWE, nLATCH0, nLATCH1
    );

    modport slave (
        input CLK_2H, CLK_1H, A, nWE, nLATCH0, nLATCH1
    );
endinterface

// File: rtl/scroll_latch_responder.sv
// scroll_latch_responder: latches CPU scroll/priority writes into
// per-plane shadow regs, copied to the active regs at vblank start.
// Ports: CLK_6M clock, nRESET async active-low reset, nVBLANK vblank,
// bus (slave) slot/strobe/address, D data (inout), SCRX/SCRY/PRIO_A/B
// active regs, DIRTY shadow!=active, COLLIDE dual-select pulse.
// Option macro: LATCH_READBACK_EN drives D with the shadow reg on reads.
module scroll_latch_responder #(
    parameter int PRIO_BITS = 3,
    parameter bit IMMEDIATE = 1'b0
) (
    input  logic                 CLK_6M,
    input  logic                 nRESET,
    input  logic                 nVBLANK,
    scroll_bus_if.slave          bus,
    inout  wire  [7:0]           D,
    output logic [8:0]           SCRX_A,
    output logic [7:0]           SCRY_A,
    output logic [PRIO_BITS-1:0] PRIO_A,
    output logic [8:0]           SCRX_B,
    output logic [7:0]           SCRY_B,
    output logic [PRIO_BITS-1:0] PRIO_B,
    output logic                 DIRTY,
    output logic                 COLLIDE
);
    localparam int PW = PRIO_BITS;

    logic          g_q, g_d;
    logic          h2_q, h2_d;
    logic          vb_q, vb_d;
    logic          vb_prev_q, vb_prev_d;
    logic          dirty_q, dirty_d;
    logic          collide_q, collide_d;

    logic [8:0]    sxa_q, sxa_d, sxb_q, sxb_d;
    logic [7:0]    sya_q, sya_d, syb_q, syb_d;
    logic [PW-1:0] spa_q, spa_d, spb_q, spb_d;
    logic [8:0]    axa_q, axa_d, axb_q, axb_d;
    logic [7:0]    aya_q, aya_d, ayb_q, ayb_d;
    logic [PW-1:0] apa_q, apa_d, apb_q, apb_d;

    logic toggle, guard_eff, sel_a, sel_b, req, wr_a, wr_b, fall;
    logic unused_a2;

    assign unused_a2 = bus.A[2];

    always_comb begin
        h2_d      = bus.CLK_2H;
        vb_d      = nVBLANK;
        vb_prev_d = vb_q;
        fall      = vb_prev_q & ~vb_q;

        // A 2H transition frees the guard on that very edge.
        toggle    = bus.CLK_2H != h2_q;
        guard_eff = g_q & ~toggle;
        sel_a     = ~bus.nLATCH0;
        sel_b     = ~bus.nLATCH1;
        req       = ~bus.CLK_1H & ~bus.nWE & ~guard_eff;
        wr_a      = req & sel_a & ~sel_b;
        wr_b      = req & sel_b & ~sel_a;
        collide_d = req & sel_a & sel_b;
        g_d       = guard_eff | wr_a | wr_b | collide_d;

        sxa_d = sxa_q;
        sya_d = sya_q;
        spa_d = spa_q;
        sxb_d = sxb_q;
        syb_d = syb_q;
        spb_d = spb_q;

        if (wr_a) begin
            unique case (bus.A[1:0])
                2'd0: begin
                    sxa_d[8] = D[0];
                    spa_d    = D[PW:1];
                end
                2'd1: sxa_d[7:0] = D;
                2'd2: sya_d      = D;
                2'd3: ;
            endcase
        end

        if (wr_b) begin
            unique case (bus.A[1:0])
                2'd0: begin
                    sxb_d[8] = D[0];
                    spb_d    = D[PW:1];
                end
                2'd1: sxb_d[7:0] = D;
                2'd2: syb_d      = D;
                2'd3: ;
            endcase
        end

        axa_d = axa_q;
        aya_d = aya_q;
        apa_d = apa_q;
        axb_d = axb_q;
        ayb_d = ayb_q;
        apb_d = apb_q;

        if (IMMEDIATE) begin
            axa_d = sxa_d;
            aya_d = sya_d;
            apa_d = spa_d;
            axb_d = sxb_d;
            ayb_d = syb_d;
            apb_d = spb_d;
        end else if (fall) begin
            // Pre-commit shadow: a coincident write waits a frame.
            axa_d = sxa_q;
            aya_d = sya_q;
            apa_d = spa_q;
            axb_d = sxb_q;
            ayb_d = syb_q;
            apb_d = spb_q;
        end

        dirty_d = IMMEDIATE ? 1'b0 :
            ({sxa_q, sya_q, spa_q, sxb_q, syb_q, spb_q} !=
             {axa_q, aya_q, apa_q, axb_q, ayb_q, apb_q});
    end

    always_ff @(posedge CLK_6M or negedge nRESET) begin
        if (!nRESET) begin
            g_q       <= 1'b0;
            h2_q      <= 1'b0;
            vb_q      <= 1'b0;
            vb_prev_q <= 1'b0;
            dirty_q   <= 1'b0;
            collide_q <= 1'b0;
            sxa_q     <= '0;
            sya_q     <= '0;
            spa_q     <= '0;
            sxb_q     <= '0;
            syb_q     <= '0;
            spb_q     <= '0;
            axa_q     <= '0;
            aya_q     <= '0;
            apa_q     <= '0;
            axb_q     <= '0;
            ayb_q     <= '0;
            apb_q     <= '0;
        end else begin
            g_q       <= g_d;
            h2_q      <= h2_d;
            vb_q      <= vb_d;
            vb_prev_q <= vb_prev_d;
            dirty_q   <= dirty_d;
            collide_q <= collide_d;
            sxa_q     <= sxa_d;
            sya_q     <= sya_d;
            spa_q     <= spa_d;
            sxb_q     <= sxb_d;
            syb_q     <= syb_d;
            spb_q     <= spb_d;
            axa_q     <= axa_d;
            aya_q     <= aya_d;
            apa_q     <= apa_d;
            axb_q     <= axb_d;
            ayb_q     <= ayb_d;
            apb_q     <= apb_d;
        end
    end

    assign SCRX_A  = axa_q;
    assign SCRY_A  = aya_q;
    assign PRIO_A  = apa_q;
    assign SCRX_B  = axb_q;
    assign SCRY_B  = ayb_q;
    assign PRIO_B  = apb_q;
    assign DIRTY   = dirty_q;
    assign COLLIDE = collide_q;

`ifdef LATCH_READBACK_EN
    logic          rd_en;
    logic [7:0]    rd_val;
    logic [8:0]    rd_x;
    logic [7:0]    rd_y;
    logic [PW-1:0] rd_p;

    always_comb begin
        rd_en  = ~bus.CLK_1H & bus.nWE & (bus.nLATCH0 ^ bus.nLATCH1);
        rd_x   = bus.nLATCH0 ? sxb_q : sxa_q;
        rd_y   = bus.nLATCH0 ? syb_q : sya_q;
        rd_p   = bus.nLATCH0 ? spb_q : spa_q;
        rd_val = 8'hFF;
        unique case (bus.A[1:0])
            2'd0: begin
                rd_val       = 8'h00;
                rd_val[PW:1] = rd_p;
                rd_val[0]    = rd_x[8];
            end
            2'd1: rd_val = rd_x[7:0];
            2'd2: rd_val = rd_y;
            2'd3: rd_val = 8'hFF;
        endcase
    end

    assign D = rd_en ? rd_val : 8'hzz;
`endif
endmodule
